// File: rtl/issue_queue_pkg.sv
// Shared sizing and issue-count encodings for the dual-issue instruction queue.
package issue_queue_pkg;
   localparam int unsigned DEPTH = 8;
   localparam int unsigned IDX_W = $clog2(DEPTH);
   localparam int unsigned PTR_W = IDX_W + 1;

   typedef logic [PTR_W-1:0] ptr_t;
   typedef logic [IDX_W-1:0] idx_t;

   typedef enum logic [1:0] {
      ISSUE_NONE = 2'd0,
      ISSUE_ONE  = 2'd1,
      ISSUE_TWO  = 2'd2
   } issue_e;

   typedef struct packed {
      logic [31:0] inst;
      logic [31:0] pc;
   } entry_t;
endpackage

// File: rtl/issue_queue_if.sv
// Fetch, issue and decoder-feedback signals of the issue queue; master is the core side.
interface issue_queue_if;
   logic [1:0]  in_valid;
   logic [31:0] in_inst0, in_inst1, in_pc0, in_pc1;
   logic        in_ready;
   logic        flush, stall;
   logic        out_valid1, out_valid2;
   logic [31:0] out_inst1, out_pc1, out_inst2, out_pc2;
   logic        d1_wreg, d1_mult_div, d1_jmp_branch, d1_load_store;
   logic [4:0]  d1_wa;
   logic [4:0]  d2_rs, d2_rt;
   logic        d2_rreg1, d2_rreg2, d2_mult_div, d2_jmp_branch, d2_load_store;
   logic [1:0]  issue_cnt;
   logic        issue_dual;

   modport master (
      output in_valid, in_inst0, in_inst1, in_pc0, in_pc1, flush, stall,
             d1_wreg, d1_wa, d1_mult_div, d1_jmp_branch, d1_load_store,
             d2_rs, d2_rt, d2_rreg1, d2_rreg2, d2_mult_div, d2_jmp_branch, d2_load_store,
      input  in_ready, out_valid1, out_valid2, out_inst1, out_pc1, out_inst2, out_pc2,
             issue_cnt, issue_dual
   );

   modport slave (
      input  in_valid, in_inst0, in_inst1, in_pc0, in_pc1, flush, stall,
             d1_wreg, d1_wa, d1_mult_div, d1_jmp_branch, d1_load_store,
             d2_rs, d2_rt, d2_rreg1, d2_rreg2, d2_mult_div, d2_jmp_branch, d2_load_store,
      output in_ready, out_valid1, out_valid2, out_inst1, out_pc1, out_inst2, out_pc2,
             issue_cnt, issue_dual
   );
endinterface

// File: rtl/issue_pair_check.sv
// Combinational issue decision: how many of the head/head+1 entries leave this cycle.
module issue_pair_check
   import issue_queue_pkg::*;
(
   input  logic       i_valid1,
   input  logic       i_valid2,
   input  logic       i_stall,
   input  logic       i_flush,
   input  logic       i_d1_wreg,
   input  logic [4:0] i_d1_wa,
   input  logic       i_d1_mult_div,
   input  logic       i_d1_jmp_branch,
   input  logic       i_d1_load_store,
   input  logic [4:0] i_d2_rs,
   input  logic [4:0] i_d2_rt,
   input  logic       i_d2_rreg1,
   input  logic       i_d2_rreg2,
   input  logic       i_d2_mult_div,
   input  logic       i_d2_jmp_branch,
   input  logic       i_d2_load_store,
   output issue_e     o_issue
);
   logic w_raw;
   logic w_hazard;

   assign w_raw = i_d1_wreg && (i_d1_wa != 5'd0) &&
                  ((i_d2_rreg1 && (i_d2_rs == i_d1_wa)) ||
                   (i_d2_rreg2 && (i_d2_rt == i_d1_wa)));

   assign w_hazard = w_raw || (i_d1_mult_div && i_d2_mult_div) ||
                     (i_d1_load_store && i_d2_load_store) || i_d2_jmp_branch;

   // A branch never issues alone: it waits for its delay slot and a clean pairing.
   always_comb begin
      o_issue = ISSUE_NONE;
      if (i_valid1 && !i_stall && !i_flush) begin
         if (i_valid2 && !w_hazard)
            o_issue = ISSUE_TWO;
         else if (!i_d1_jmp_branch)
            o_issue = ISSUE_ONE;
      end
   end
endmodule

// File: rtl/issue_queue.sv
// Circular dual-push/dual-pop instruction queue between fetch and the two decoders.
module issue_queue
   import issue_queue_pkg::*;
(
   input logic          clk,
   input logic          resetn,
   issue_queue_if.slave q
);
   entry_t r_mem [DEPTH];
   ptr_t   r_head, r_tail;
   ptr_t   w_count, w_push_n;
   idx_t   w_head_idx, w_head1_idx, w_tail_idx, w_tail1_idx;
   logic   w_push;
   logic [1:0] w_cnt;
   issue_e w_issue;

   assign w_count     = r_tail - r_head;
   assign w_head_idx  = r_head[IDX_W-1:0];
   assign w_head1_idx = w_head_idx + idx_t'(1);
   assign w_tail_idx  = r_tail[IDX_W-1:0];
   assign w_tail1_idx = w_tail_idx + idx_t'(1);

   assign q.in_ready   = (w_count <= ptr_t'(DEPTH - 2));
   assign q.out_valid1 = (w_count != '0);
   assign q.out_valid2 = (w_count >= ptr_t'(2));
   assign q.out_inst1  = r_mem[w_head_idx].inst;
   assign q.out_pc1    = r_mem[w_head_idx].pc;
   assign q.out_inst2  = r_mem[w_head1_idx].inst;
   assign q.out_pc2    = r_mem[w_head1_idx].pc;

   // The illegal 2'b10 pattern has no valid older slot and is treated as no push.
   assign w_push   = q.in_ready && q.in_valid[0] && !q.flush;
   assign w_push_n = q.in_valid[1] ? ptr_t'(2) : ptr_t'(1);

   issue_pair_check u_pair (
      .i_valid1        (q.out_valid1),
      .i_valid2        (q.out_valid2),
      .i_stall         (q.stall),
      .i_flush         (q.flush),
      .i_d1_wreg       (q.d1_wreg),
      .i_d1_wa         (q.d1_wa),
      .i_d1_mult_div   (q.d1_mult_div),
      .i_d1_jmp_branch (q.d1_jmp_branch),
      .i_d1_load_store (q.d1_load_store),
      .i_d2_rs         (q.d2_rs),
      .i_d2_rt         (q.d2_rt),
      .i_d2_rreg1      (q.d2_rreg1),
      .i_d2_rreg2      (q.d2_rreg2),
      .i_d2_mult_div   (q.d2_mult_div),
      .i_d2_jmp_branch (q.d2_jmp_branch),
      .i_d2_load_store (q.d2_load_store),
      .o_issue         (w_issue)
   );

   assign w_cnt        = w_issue;
   assign q.issue_cnt  = w_cnt;
   assign q.issue_dual = (w_issue == ISSUE_TWO);

   always_ff @(posedge clk) begin
      if (w_push) begin
         r_mem[w_tail_idx] <= '{inst: q.in_inst0, pc: q.in_pc0};
         if (q.in_valid[1])
            r_mem[w_tail1_idx] <= '{inst: q.in_inst1, pc: q.in_pc1};
      end
   end

   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         r_head <= '0;
         r_tail <= '0;
      end else if (q.flush) begin
         r_head <= '0;
         r_tail <= '0;
      end else begin
         r_head <= r_head + ptr_t'(w_cnt);
         if (w_push)
            r_tail <= r_tail + w_push_n;
      end
   end
endmodule

// File: tb/tb_issue_queue.sv
// Directed and mixed stimulus for issue_queue, checked every cycle against a queue-based model.
module tb_issue_queue;
   import issue_queue_pkg::*;

   localparam logic [31:0] ADDU = 32'h0022_1821; // addu $3,$1,$2
   localparam logic [31:0] OR46 = 32'h00A6_2025; // or   $4,$5,$6
   localparam logic [31:0] SUB7 = 32'h0061_3822; // sub  $7,$3,$1
   localparam logic [31:0] BEQ  = 32'h1022_0004; // beq  $1,$2,+4
   localparam logic [31:0] NOP  = 32'h0000_0000;

   typedef struct {
      logic [31:0] inst;
      logic [31:0] pc;
   } ent_t;

   typedef struct packed {
      logic       wreg;
      logic [4:0] wa;
      logic       rreg1, rreg2;
      logic [4:0] rs, rt;
      logic       md, jb, ls;
   } dec_t;

   logic clk = 1'b0;
   logic resetn = 1'b0;
   always #5 clk = ~clk;

   issue_queue_if bus ();
   issue_queue u_dut (.clk(clk), .resetn(resetn), .q(bus));

   ent_t mq[$];
   int   n_checks = 0;
   int   n_fail = 0;
   logic [31:0] pc_next = 32'h0000_1000;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h, expected %h at %0t", name, act, exp, $time);
      end
   endtask

   function automatic dec_t decode(input logic [31:0] w);
      dec_t d;
      d = '0;
      d.rs = w[25:21];
      d.rt = w[20:16];
      case (w[31:26])
         6'h00: begin
            d.rreg1 = 1'b1;
            d.rreg2 = 1'b1;
            case (w[5:0])
               6'h08, 6'h09: d.jb = 1'b1;
               6'h18, 6'h19, 6'h1a, 6'h1b: d.md = 1'b1;
               default: begin d.wreg = 1'b1; d.wa = w[15:11]; end
            endcase
         end
         6'h02, 6'h03: d.jb = 1'b1;
         6'h04, 6'h05: begin d.jb = 1'b1; d.rreg1 = 1'b1; d.rreg2 = 1'b1; end
         6'h23: begin d.wreg = 1'b1; d.wa = d.rt; d.rreg1 = 1'b1; d.ls = 1'b1; end
         6'h2b: begin d.rreg1 = 1'b1; d.rreg2 = 1'b1; d.ls = 1'b1; end
         default: begin d.wreg = 1'b1; d.wa = d.rt; d.rreg1 = 1'b1; end
      endcase
      return d;
   endfunction

   // Non-branch instruction with small register numbers so RAW pairs are frequent.
   function automatic logic [31:0] rand_inst();
      logic [4:0] rs, rt, rd;
      rs = 5'($urandom_range(0, 7));
      rt = 5'($urandom_range(0, 7));
      rd = 5'($urandom_range(0, 7));
      case ($urandom_range(0, 5))
         0: return {6'h00, rs, rt, rd, 5'd0, 6'h21};
         1: return {6'h00, rs, rt, rd, 5'd0, 6'h22};
         2: return {6'h00, rs, rt, 10'd0, 6'h18};
         3: return {6'h00, rs, rt, 10'd0, 6'h1a};
         4: return {6'h23, rs, rt, 16'h0010};
         default: return {6'h2b, rs, rt, 16'h0020};
      endcase
   endfunction

   // Decoder feedback comes from the model's own head entries; absent entries get noise.
   task automatic drive_fb();
      dec_t d1, d2;
      d1 = (mq.size() >= 1) ? decode(mq[0].inst) : dec_t'($urandom);
      d2 = (mq.size() >= 2) ? decode(mq[1].inst) : dec_t'($urandom);
      bus.d1_wreg = d1.wreg;  bus.d1_wa = d1.wa;  bus.d1_mult_div = d1.md;
      bus.d1_jmp_branch = d1.jb;  bus.d1_load_store = d1.ls;
      bus.d2_rs = d2.rs;  bus.d2_rt = d2.rt;  bus.d2_rreg1 = d2.rreg1;  bus.d2_rreg2 = d2.rreg2;
      bus.d2_mult_div = d2.md;  bus.d2_jmp_branch = d2.jb;  bus.d2_load_store = d2.ls;
   endtask

   task automatic cycle(input logic [1:0] v, input logic [31:0] i0, input logic [31:0] i1,
                        input logic st, input logic fl);
      @(posedge clk);
      #1;
      bus.in_valid = v;
      bus.in_inst0 = i0;
      bus.in_pc0   = pc_next;
      bus.in_inst1 = i1;
      bus.in_pc1   = pc_next + 32'd4;
      pc_next      = pc_next + 32'd8;
      bus.stall    = st;
      bus.flush    = fl;
      drive_fb();
   endtask

   always @(negedge resetn) mq.delete();

   always @(negedge clk) begin : compare
      int n, e;
      dec_t d1, d2;
      logic hz, rdy;
      if (!resetn) begin
         chk("rst_out_valid1", 32'(bus.out_valid1), 32'd0);
         chk("rst_out_valid2", 32'(bus.out_valid2), 32'd0);
         chk("rst_in_ready",   32'(bus.in_ready),   32'd1);
         chk("rst_issue_cnt",  32'(bus.issue_cnt),  32'd0);
         chk("rst_issue_dual", 32'(bus.issue_dual), 32'd0);
      end else begin
         n   = mq.size();
         rdy = (n <= int'(DEPTH) - 2);
         chk("in_ready",   32'(bus.in_ready),   32'(rdy));
         chk("out_valid1", 32'(bus.out_valid1), 32'(n >= 1));
         chk("out_valid2", 32'(bus.out_valid2), 32'(n >= 2));
         if (n >= 1) begin
            chk("out_inst1", bus.out_inst1, mq[0].inst);
            chk("out_pc1",   bus.out_pc1,   mq[0].pc);
         end
         if (n >= 2) begin
            chk("out_inst2", bus.out_inst2, mq[1].inst);
            chk("out_pc2",   bus.out_pc2,   mq[1].pc);
         end
         d1 = (n >= 1) ? decode(mq[0].inst) : '0;
         d2 = (n >= 2) ? decode(mq[1].inst) : '0;
         hz = (d1.wreg && d1.wa != 5'd0 &&
               ((d2.rreg1 && d2.rs == d1.wa) || (d2.rreg2 && d2.rt == d1.wa))) ||
              (d1.md && d2.md) || (d1.ls && d2.ls) || d2.jb;
         if (bus.stall || bus.flush || n == 0) e = 0;
         else if (d1.jb && n < 2)              e = 0;
         else if (n >= 2 && !hz)               e = 2;
         else if (d1.jb)                       e = 0;
         else                                  e = 1;
         chk("issue_cnt",  32'(bus.issue_cnt),  32'(e));
         chk("issue_dual", 32'(bus.issue_dual), 32'(e == 2));
         if (bus.flush) mq.delete();
         else begin
            repeat (e) void'(mq.pop_front());
            if (rdy && bus.in_valid[0]) begin
               mq.push_back('{inst: bus.in_inst0, pc: bus.in_pc0});
               if (bus.in_valid[1]) mq.push_back('{inst: bus.in_inst1, pc: bus.in_pc1});
            end
         end
      end
   end

   initial begin
      bus.in_valid = 2'b00;  bus.in_inst0 = '0;  bus.in_inst1 = '0;
      bus.in_pc0 = '0;  bus.in_pc1 = '0;  bus.stall = 1'b0;  bus.flush = 1'b0;
      drive_fb();
      repeat (2) @(posedge clk);
      #2 resetn = 1'b1;

      // Independent pair issues together.
      cycle(2'b11, ADDU, OR46, 1'b0, 1'b0);
      cycle(2'b00, NOP, NOP, 1'b0, 1'b0);  #1;
      chk("pair_issue_cnt", 32'(bus.issue_cnt), 32'd2);
      chk("pair_inst2", bus.out_inst2, OR46);
      cycle(2'b00, NOP, NOP, 1'b0, 1'b0);  #1;
      chk("pair_empty", 32'(bus.out_valid1), 32'd0);

      // RAW on $3 splits the pair.
      cycle(2'b11, ADDU, SUB7, 1'b0, 1'b0);
      cycle(2'b00, NOP, NOP, 1'b0, 1'b0);  #1;
      chk("raw_first", 32'(bus.issue_cnt), 32'd1);
      cycle(2'b00, NOP, NOP, 1'b0, 1'b0);  #1;
      chk("raw_second", 32'(bus.issue_cnt), 32'd1);
      chk("raw_second_inst", bus.out_inst1, SUB7);

      // Branch waits for its delay slot.
      cycle(2'b01, BEQ, NOP, 1'b0, 1'b0);
      cycle(2'b01, NOP, NOP, 1'b0, 1'b0);  #1;
      chk("beq_alone", 32'(bus.issue_cnt), 32'd0);
      cycle(2'b00, NOP, NOP, 1'b0, 1'b0);  #1;
      chk("beq_slot", 32'(bus.issue_cnt), 32'd2);

      // Stalled fill to 7: in_ready drops and a further push is dropped.
      cycle(2'b01, OR46, NOP, 1'b1, 1'b0);
      repeat (3) cycle(2'b11, OR46, ADDU, 1'b1, 1'b0);
      cycle(2'b11, ADDU, ADDU, 1'b1, 1'b0);  #1;
      chk("full7_ready", 32'(bus.in_ready), 32'd0);
      cycle(2'b00, NOP, NOP, 1'b1, 1'b0);  #1;
      chk("full7_hold_ready", 32'(bus.in_ready), 32'd0);
      repeat (8) cycle(2'b00, NOP, NOP, 1'b0, 1'b0);

      // Flush at count 5 with a simultaneous push.
      cycle(2'b01, OR46, NOP, 1'b1, 1'b0);
      repeat (2) cycle(2'b11, OR46, ADDU, 1'b1, 1'b0);
      cycle(2'b11, ADDU, OR46, 1'b0, 1'b1);  #1;
      chk("flush_issue", 32'(bus.issue_cnt), 32'd0);
      cycle(2'b00, NOP, NOP, 1'b0, 1'b0);  #1;
      chk("flush_valid1", 32'(bus.out_valid1), 32'd0);
      chk("flush_ready", 32'(bus.in_ready), 32'd1);

      // Asynchronous reset pulse between edges at count 6.
      repeat (3) cycle(2'b11, OR46, ADDU, 1'b1, 1'b0);
      cycle(2'b00, NOP, NOP, 1'b1, 1'b0);
      #1 chk("pre_rst_valid2", 32'(bus.out_valid2), 32'd1);
      resetn = 1'b0;
      #1;
      chk("async_rst_valid1", 32'(bus.out_valid1), 32'd0);
      chk("async_rst_ready", 32'(bus.in_ready), 32'd1);
      #1 resetn = 1'b1;

      // Mixed traffic across pointer wraps.
      for (int c = 0; c < 200; c++) begin
         int r;
         r = $urandom_range(0, 15);
         if (r == 0)
            cycle(2'b11, BEQ, NOP, 1'($urandom_range(0, 2) == 0), 1'b0);
         else if (r == 1 && c % 50 == 49)
            cycle(2'b11, rand_inst(), rand_inst(), 1'b0, 1'b1);
         else
            cycle((r < 6) ? 2'b00 : (r < 10) ? 2'b01 : 2'b11, rand_inst(), rand_inst(),
                  1'($urandom_range(0, 3) == 0), 1'b0);
      end
      repeat (12) cycle(2'b00, NOP, NOP, 1'b0, 1'b0);
      @(posedge clk);
      #1;
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end
endmodule

// File: doc/issue_queue.md
ISSUE_QUEUE -- requirements
Module: issue_queue

Interface
REQ-001 DEPTH, 8, queue entries (power of two, >= 4).
REQ-002 clk  input  1  single clock; all state updates on rising edge.
REQ-003 resetn  input  1  reset, asynchronous and active-low.
REQ-004 in_valid  input  2  fetch-slot valids; bit0 = older slot; 2'b10 illegal.
REQ-005 in_inst0, in_inst1  input  32 each  fetched instruction words.
REQ-006 in_pc0, in_pc1  input  32 each  PCs of the fetched instructions.
REQ-007 in_ready  output  1  high when free entries >= 2.
REQ-008 flush  input  1  discard all entries (exception or branch redirect).
REQ-009 stall  input  1  back-end stall; no pop this cycle.
REQ-010 out_valid1, out_valid2  output  1 each  head / head+1 entry present.
REQ-011 out_inst1, out_pc1, out_inst2, out_pc2  output  32 each  head / head+1 contents, toward decoders 1 and 2.
REQ-012 d1_wreg, d1_wa[4:0], d1_mult_div, d1_jmp_branch, d1_load_store  input  decoder-1 feedback for out_inst1.
REQ-013 d2_rs[4:0], d2_rt[4:0], d2_rreg1, d2_rreg2, d2_mult_div, d2_jmp_branch, d2_load_store  input  decoder-2 feedback for out_inst2.
REQ-014 issue_cnt  output  2  entries consumed this cycle (0, 1 or 2).
REQ-015 issue_dual  output  1  equals (issue_cnt == 2).

Function
REQ-016 Storage: DEPTH x {inst, pc}; head/tail pointers of log2(DEPTH)+1 bits, MSB is wrap bit; count = tail - head.
REQ-017 Push when in_ready and in_valid != 0: write slot0 at tail, slot1 at tail+1 if in_valid[1]; tail advances by popcount(in_valid).
REQ-018 Push while in_ready low is dropped; fetch holds its data (no overflow, no count change).
REQ-019 out_valid1 = (count >= 1); out_valid2 = (count >= 2); outputs are combinational reads of head and head+1 modulo DEPTH.
REQ-020 issue_cnt = 0 if stall, flush, or !out_valid1.
REQ-021 issue_cnt = 0 if d1_jmp_branch and !out_valid2 (branch waits for its delay slot).
REQ-022 issue_cnt = 2 if out_valid2 and none of the pairing hazards in REQ-023 apply; otherwise 1.
REQ-023 Pairing hazards: d1_wreg, d1_wa != 0, and ((d2_rreg1 and d2_rs == d1_wa) or (d2_rreg2 and d2_rt == d1_wa)); d1_mult_div and d2_mult_div; d1_load_store and d2_load_store; d2_jmp_branch.
REQ-024 A pairing hazard with d1_jmp_branch high gives issue_cnt = 0, never 1, so the branch and its delay slot issue together on a later cycle.
REQ-025 head advances by issue_cnt at the clock edge.
REQ-026 Simultaneous push and pop in one cycle: count_next = count + pushed - issue_cnt; in_ready is computed from the current count only.
REQ-027 Pointer wrap: index = pointer modulo DEPTH; full = count == DEPTH; empty = count == 0; correct across any wrap.
REQ-028 flush: head <= tail <= 0 at the edge; pushes in the flush cycle are discarded; issue_cnt = 0 in that cycle.
REQ-029 Decoder feedback is sampled only when the matching out_valid is high; otherwise it is ignored.

Reset
REQ-030 While resetn is low: head = tail = 0, storage is not cleared, out_valid1 = out_valid2 = 0, in_ready = 1, issue_cnt = 0, issue_dual = 0.
REQ-031 Reset asserted mid-operation takes effect immediately and drops all queued entries.

Structure
REQ-032 The shared defines file holds DEPTH, the pointer width and the ISSUE_NONE/ONE/TWO encodings.
REQ-033 Sub-module issue_pair_check: purely combinational REQ-020..REQ-024 decision; the parent holds the storage and pointers.

Verification
REQ-034 Reset, then push {addu $3,$1,$2; or $4,$5,$6} -> next cycle issue_cnt = 2, count = 0.
REQ-035 Queue holds {addu $3,..; sub $7,$3,$1} -> RAW on $3 gives issue_cnt = 1, then issue_cnt = 1 the next cycle.
REQ-036 Queue holds only beq -> issue_cnt = 0; push the delay slot nop -> issue_cnt = 2.
REQ-037 Push 2 per cycle with stall = 1 -> in_ready drops at count = 7; count never exceeds 8; 200 mixed cycles cross a pointer wrap with entries returned in FIFO order.
REQ-038 count = 5 with flush and in_valid = 2'b11 -> next cycle count = 0, out_valid1 = 0.
REQ-039 resetn pulsed low asynchronously between edges at count = 6 -> out_valid1 falls immediately and in_ready = 1.
